// File: rtl/es2.sv
// Two-digit combination lock: edge-detected entry strobe, Moore FSM.
// Ports: reset (async low), comb1/comb2 digits, enter strobe, open/error, clk.
module es2 #(
  parameter logic CODE1 = 1'b1,
  parameter logic CODE2 = 1'b1
) (
  input  logic reset,
  input  logic comb1,
  input  logic comb2,
  input  logic enter,
  output logic open,
  output logic error,
  input  logic clk
);

  typedef enum logic [2:0] {
    IDLE,
    FIRST_OK,
    FIRST_BAD,
    OPENED,
    FAILED
  } state_t;

  state_t state;
  state_t state_nx;
  logic   enter_q;
  logic   entry;
  logic   open_nx;
  logic   error_nx;

  // A held strobe counts once; low for a cycle re-arms.
  assign entry = enter & ~enter_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      enter_q <= 1'b0;
      open    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_nx;
      enter_q <= enter;
      open    <= open_nx;
      error   <= error_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (entry)
          state_nx = (comb1 == CODE1) ? FIRST_OK : FIRST_BAD;
      end
      FIRST_OK: begin
        if (entry)
          state_nx = (comb2 == CODE2) ? OPENED : FAILED;
      end
      // Wrong first digit stays hidden until the second entry.
      FIRST_BAD: begin
        if (entry)
          state_nx = FAILED;
      end
      OPENED:  state_nx = OPENED;
      FAILED:  state_nx = FAILED;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs registered from the next state so they track state exactly.
  always_comb begin
    open_nx  = (state_nx == OPENED);
    error_nx = (state_nx == FAILED);
  end

endmodule

// File: tb/tb_es2.sv
// Self-checking bench for es2: directed vector table, async reset
// sequence, and random stimulus against an entry-counting model.
module tb_es2;

  localparam logic CODE1 = 1'b1;
  localparam logic CODE2 = 1'b1;

  logic clk;
  logic reset;
  logic comb1;
  logic comb2;
  logic enter;
  logic open;
  logic error;

  int checks = 0;
  int errors = 0;

  es2 #(
    .CODE1(CODE1),
    .CODE2(CODE2)
  ) dut (
    .reset(reset),
    .comb1(comb1),
    .comb2(comb2),
    .enter(enter),
    .open (open),
    .error(error),
    .clk  (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic c1;
    logic c2;
    logic en;
    logic eo;
    logic ee;
  } vec_t;

  vec_t vecs[$];

  // Reference model: count accepted entries, remember sampled digits.
  int   m_n;
  logic m_prev;
  logic m_d1;
  logic m_d2;

  function automatic void add(input logic r, input logic a,
                              input logic b, input logic e,
                              input logic o, input logic x);
    vec_t v;
    v.rst = r; v.c1 = a; v.c2 = b; v.en = e; v.eo = o; v.ee = x;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic o,
                       input logic x);
    checks++;
    if (open !== o || error !== x) begin
      errors++;
      $display("FAIL %s: open=%b error=%b, required open=%b error=%b",
               name, open, error, o, x);
    end
  endtask

  task automatic drive(input logic r, input logic a,
                       input logic b, input logic e);
    @(negedge clk);
    reset = r; comb1 = a; comb2 = b; enter = e;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    if (!reset) begin
      m_n = 0;
      m_prev = 1'b0;
    end else begin
      if (enter && !m_prev) begin
        if (m_n == 0) begin
          m_d1 = comb1; m_n = 1;
        end else if (m_n == 1) begin
          m_d2 = comb2; m_n = 2;
        end
      end
      m_prev = enter;
    end
  endtask

  initial begin
    logic eo;
    logic ex;
    reset = 1'b0; comb1 = 1'b0; comb2 = 1'b0; enter = 1'b0;

    // reset state
    add(0, 0, 0, 0, 0, 0);
    // correct combination, then ignored entries in OPENED
    add(1, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0);
    add(1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0);
    // wrong second digit
    add(1, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1);
    add(1, 1, 1, 0, 0, 1);
    add(1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    // wrong first digit hidden until second entry
    add(1, 0, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    // long strobe counts once
    add(1, 1, 0, 1, 0, 0);
    add(1, 1, 1, 1, 0, 0);
    add(1, 1, 1, 1, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0);
    // entries during reset ignored; high enter at release counts
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0);
    // reset mid-sequence discards progress
    add(0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].c1, vecs[i].c2, vecs[i].en);
      check($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ee);
    end

    // Async reset while OPENED clears outputs before the next edge
    drive(0, 0, 0, 0);
    drive(1, 1, 0, 1);
    drive(1, 1, 0, 0);
    drive(1, 1, 1, 1);
    check("open_before_async", 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 check("async_reset", 1'b0, 1'b0);
    drive(0, 0, 0, 0);

    // Random stimulus against the model
    m_n = 0; m_prev = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 39) != 0),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0));
      model_step();
      eo = (m_n == 2) && (m_d1 == CODE1) && (m_d2 == CODE2);
      ex = (m_n == 2) && !eo;
      check($sformatf("rand%0d", i), eo, ex);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/es2.md
ES2 -- requirements
Module: es2

Interface
REQ-001 Parameter CODE1, default 1'b1, required value of comb1 at the first entry.
REQ-002 Parameter CODE2, default 1'b1, required value of comb2 at the second entry.
REQ-003 Port order SHALL be reset, comb1, comb2, enter, open, error, clk.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-006 comb1  input  1  first combination digit; sampled only at the first accepted entry.
REQ-007 comb2  input  1  second combination digit; sampled only at the second accepted entry.
REQ-008 enter  input  1  entry strobe; an entry is accepted on a rising edge of enter.
REQ-009 open  output  1  registered; 1 = correct two-digit combination accepted, locker open.
REQ-010 error  output  1  registered; 1 = wrong combination entered.

Function
REQ-011 The block SHALL register enter every clock (enter_q, reset value 0) and accept an entry on any clock edge where enter=1 and enter_q=0.
REQ-012 enter held high for several cycles SHALL count as one entry; enter low for at least one cycle re-arms detection.
REQ-013 FSM states SHALL be IDLE, FIRST_OK, FIRST_BAD, OPENED, FAILED; reset state IDLE.
REQ-014 IDLE, entry accepted: comb1==CODE1 -> FIRST_OK, else -> FIRST_BAD; no entry -> stay.
REQ-015 FIRST_OK, entry accepted: comb2==CODE2 -> OPENED, else -> FAILED; no entry -> stay.
REQ-016 FIRST_BAD, entry accepted -> FAILED regardless of comb2; no entry -> stay.
REQ-017 The design SHALL NOT reveal after the first entry which digit was wrong; error rises only after the second entry.
REQ-018 OPENED and FAILED SHALL be terminal: further entries and comb changes ignored until reset.
REQ-019 open SHALL be 1 exactly when state is OPENED; error 1 exactly when state is FAILED; never both 1.
REQ-020 Outputs SHALL be driven from registers (Moore); open/error assert on the clock edge that accepts the second entry, visible the same cycle after that edge.
REQ-021 Latency: first accepted entry at edge N, second at edge M>N -> open or error valid after edge M.
REQ-022 comb1/comb2 values at any time other than their sampling edge SHALL have no effect.

Reset
REQ-023 reset=0 SHALL asynchronously set state=IDLE, enter_q=0, open=0, error=0.
REQ-024 Reset asserted mid-sequence (FIRST_OK/FIRST_BAD) or in a terminal state SHALL discard all progress; after release a full two-entry sequence is required.
REQ-025 Entries while reset=0 SHALL be ignored; enter already high on the first edge after release SHALL count as an entry (enter_q is 0).

Verification
REQ-026 Release reset, comb1=1 enter=1 one cycle, enter=0 one cycle, comb2=1 enter=1 one cycle -> open=1, error=0 after second entry edge, held until reset.
REQ-027 Same with comb2=0 at second entry -> error=1, open=0 after second entry edge.
REQ-028 comb1=0 at first entry, comb2=1 at second -> open=0 and error=0 after first entry, error=1 after second.
REQ-029 enter held high 3 cycles with comb1=1, then low, then second entry comb2=1 -> open=1 (long strobe counts once).
REQ-030 After open=1, pulse reset low mid-cycle -> open=0 immediately (async); reset mid-sequence after first entry, then one entry only -> open=0, error=0.
REQ-031 In OPENED, apply further entries with comb1=0/comb2=0 -> open stays 1, error stays 0.
